// File: rtl/gzip_bit_packer.sv
// DEFLATE bit packer: gathers LSB-first variable-length codes into OUT_WIDTH-bit words
// on a valid/ready stream, with byte-aligned flush and a final out_last beat.
module gzip_bit_packer #(
    parameter int unsigned OUT_WIDTH    = 32,
    parameter int unsigned MAX_CODE_LEN = 32,
    parameter int unsigned LEN_WIDTH    = $clog2(MAX_CODE_LEN + 1),
    parameter int unsigned BYTES_WIDTH  = $clog2(OUT_WIDTH / 8 + 1)
) (
    input  logic                    core_clock,
    input  logic                    bus_reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MAX_CODE_LEN-1:0] in_data,
    input  logic [LEN_WIDTH-1:0]    in_len,
    input  logic                    in_flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [BYTES_WIDTH-1:0]  out_bytes,
    output logic                    out_last,
    output logic [31:0]             byte_count
);

    localparam int unsigned ACC_W  = OUT_WIDTH + MAX_CODE_LEN - 1;
    // Headroom for rounding the largest possible fill up to a byte boundary
    localparam int unsigned FILL_W = $clog2(OUT_WIDTH + MAX_CODE_LEN + 8);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_LAST  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [31:0]             byte_count_q, byte_count_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
    logic [BYTES_WIDTH-1:0]  out_bytes_q, out_bytes_d;
    logic                    out_last_q, out_last_d;

    logic                    in_fire;
    logic                    out_fire;
    logic [LEN_WIDTH-1:0]    len_clamp;
    logic [MAX_CODE_LEN-1:0] code_mask;
    logic [FILL_W-1:0]       fill_sum;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // Next-state for the accumulator, fill and FSM
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        byte_count_d = byte_count_q;
        fill_sum     = fill_q;
        len_clamp    = in_len;
        code_mask    = '1;

        if (in_len > LEN_WIDTH'(MAX_CODE_LEN)) begin
            len_clamp = LEN_WIDTH'(MAX_CODE_LEN);
        end
        if (len_clamp < LEN_WIDTH'(MAX_CODE_LEN)) begin
            code_mask = (MAX_CODE_LEN'(1) << len_clamp) - MAX_CODE_LEN'(1);
        end

        if (out_fire) begin
            byte_count_d = byte_count_q + 32'(out_bytes_q);
        end

        case (state_q)
            S_RUN: begin
                // in_ready and out_valid are exclusive in RUN, so only one side moves
                if (in_fire) begin
                    acc_d    = acc_q | (ACC_W'(in_data & code_mask) << fill_q);
                    fill_sum = fill_q + FILL_W'(len_clamp);
                    if (in_flush) begin
                        fill_sum = (fill_sum + FILL_W'(7)) & ~FILL_W'(7);
                        state_d  = (fill_sum > FILL_W'(OUT_WIDTH)) ? S_FLUSH : S_LAST;
                    end
                    fill_d = fill_sum;
                end else if (out_fire) begin
                    acc_d  = acc_q >> OUT_WIDTH;
                    fill_d = fill_q - FILL_W'(OUT_WIDTH);
                end
            end
            S_FLUSH: begin
                if (out_fire) begin
                    acc_d   = acc_q >> OUT_WIDTH;
                    fill_d  = fill_q - FILL_W'(OUT_WIDTH);
                    state_d = (fill_d > FILL_W'(OUT_WIDTH)) ? S_FLUSH : S_LAST;
                end
            end
            S_LAST: begin
                if (out_fire) begin
                    acc_d   = '0;
                    fill_d  = '0;
                    state_d = S_RUN;
                end
            end
            default: begin
                acc_d   = '0;
                fill_d  = '0;
                state_d = S_RUN;
            end
        endcase
    end

    // Output registers are loaded from the next state so they line up with it
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = acc_d[OUT_WIDTH-1:0];
        out_bytes_d = BYTES_WIDTH'(OUT_WIDTH / 8);

        case (state_d)
            S_RUN: begin
                in_ready_d  = (fill_d < FILL_W'(OUT_WIDTH));
                out_valid_d = (fill_d >= FILL_W'(OUT_WIDTH));
            end
            S_FLUSH: begin
                out_valid_d = (fill_d > FILL_W'(OUT_WIDTH));
            end
            S_LAST: begin
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                out_bytes_d = BYTES_WIDTH'(fill_d >> 3);
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            state_q      <= S_RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            byte_count_q <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_bytes_q  <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            byte_count_q <= byte_count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_bytes_q  <= out_bytes_d;
            out_last_q   <= out_last_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_bytes  = out_bytes_q;
    assign out_last   = out_last_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_gzip_bit_packer.sv
// Scoreboard bench for gzip_bit_packer: a bit-queue model predicts each output beat,
// a negedge monitor records handshaked beats, and each scenario task compares them.
module tb_gzip_bit_packer;

    logic        core_clock = 1'b0;
    logic        bus_reset  = 1'b1;
    logic        in_valid   = 1'b0;
    logic        in_ready;
    logic [31:0] in_data    = '0;
    logic [5:0]  in_len     = '0;
    logic        in_flush   = 1'b0;
    logic        out_valid;
    logic        out_ready  = 1'b1;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic [31:0] byte_count;

    gzip_bit_packer dut (
        .core_clock (core_clock),
        .bus_reset  (bus_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bytes  (out_bytes),
        .out_last   (out_last),
        .byte_count (byte_count)
    );

    always #5 core_clock = ~core_clock;

    typedef struct {
        logic [31:0] data;
        int          bytes;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    bit          model_bits[$];
    int unsigned model_bytes = 0;
    int          n_checks    = 0;
    int          n_fail      = 0;

    // Outputs are stable between edges, so a negedge sample sees the coming handshake
    always @(negedge core_clock) begin
        if (!bus_reset && out_valid && out_ready) begin
            obs_q.push_back('{data: out_data, bytes: int'(out_bytes), last: out_last});
        end
    end

    function automatic void model_emit(input int nbits, input bit last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < nbits; i++) b.data[i] = model_bits.pop_front();
        b.bytes = last ? nbits / 8 : 4;
        b.last  = last;
        model_bytes += b.bytes;
        exp_q.push_back(b);
    endfunction

    function automatic void model_push(input logic [31:0] d, input int len, input bit flush);
        int l = (len > 32) ? 32 : len;
        for (int i = 0; i < l; i++) model_bits.push_back(d[i]);
        if (!flush) begin
            while (model_bits.size() >= 32) model_emit(32, 1'b0);
        end else begin
            while ((model_bits.size() % 8) != 0) model_bits.push_back(1'b0);
            while (model_bits.size() > 32) model_emit(32, 1'b0);
            model_emit(model_bits.size(), 1'b1);
        end
    endfunction

    task automatic send_beat(input logic [31:0] d, input int len, input bit flush);
        int t = 0;
        model_push(d, len, flush);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = 6'(len);
        in_flush = flush;
        @(negedge core_clock);
        while (!in_ready && t < 200) begin
            @(negedge core_clock);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(posedge core_clock);
        #1;
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        beat_t e, o;
        while (obs_q.size() < exp_q.size() && t < 200) begin
            @(posedge core_clock);
            #1;
            t++;
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d beats, required %0d", name, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.data !== e.data || o.bytes !== e.bytes || o.last !== e.last) begin
                n_fail++;
                $display("FAIL %s_beat: got data=%h bytes=%0d last=%0b, required data=%h bytes=%0d last=%0b",
                         name, o.data, o.bytes, o.last, e.data, e.bytes, e.last);
            end
        end
        obs_q.delete();
        exp_q.delete();
        n_checks++;
        if (byte_count !== model_bytes) begin
            n_fail++;
            $display("FAIL %s_byte_count: got %0d, required %0d", name, byte_count, model_bytes);
        end
    endtask

    task automatic apply_reset();
        @(posedge core_clock);
        #1;
        bus_reset = 1'b1;
        model_bits.delete();
        exp_q.delete();
        model_bytes = 0;
        @(posedge core_clock);
        #1;
        obs_q.delete();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 ||
            out_bytes !== 3'd0 || out_last !== 1'b0 || byte_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b data=%h bytes=%0d last=%0b bc=%0d, required all 0",
                     in_ready, out_valid, out_data, out_bytes, out_last, byte_count);
        end
        bus_reset = 1'b0;
        @(posedge core_clock);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_bytes();
        send_beat(32'h11, 8, 1'b0);
        send_beat(32'h22, 8, 1'b0);
        send_beat(32'h33, 8, 1'b0);
        send_beat(32'h44, 8, 1'b0);
        drain("bytes");
        n_checks++;
        if (byte_count !== 32'd4) begin
            n_fail++;
            $display("FAIL bytes_literal_bc: got %0d, required 4", byte_count);
        end
    endtask

    task automatic test_straddle_flush();
        apply_reset();
        send_beat(32'hABCDE, 20, 1'b0);
        send_beat(32'h12345, 20, 1'b0);
        send_beat(32'h0, 0, 1'b1);
        drain("straddle");
        n_checks++;
        if (byte_count !== 32'd5) begin
            n_fail++;
            $display("FAIL straddle_literal_bc: got %0d, required 5", byte_count);
        end
    endtask

    task automatic test_mask_pad();
        send_beat(32'hFF, 4, 1'b0);
        send_beat(32'h00, 4, 1'b0);
        send_beat(32'hFFFF_FFFD, 3, 1'b1);
        drain("mask_pad");
    endtask

    task automatic test_flush_only();
        apply_reset();
        send_beat(32'h0, 0, 1'b1);
        drain("flush_only");
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_only_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_clamp_and_long_flush();
        send_beat(32'h7, 3, 1'b0);
        send_beat(32'hDEADBEEF, 40, 1'b0);
        send_beat(32'hCAFEF00D, 32, 1'b0);
        send_beat(32'h1F, 31, 1'b1);
        drain("long_flush");
    endtask

    task automatic test_hold();
        logic [31:0] first;
        out_ready = 1'b0;
        send_beat(32'h11, 8, 1'b0);
        send_beat(32'h22, 8, 1'b0);
        send_beat(32'h33, 8, 1'b0);
        send_beat(32'h44, 8, 1'b0);
        first = out_data;
        n_checks++;
        if (out_valid !== 1'b1 || first !== exp_q[0].data) begin
            n_fail++;
            $display("FAIL hold_first: got vld=%0b data=%h, required vld=1 data=%h",
                     out_valid, first, exp_q[0].data);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge core_clock);
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== first || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable: cycle %0d got rdy=%0b vld=%0b data=%h, required rdy=0 vld=1 data=%h",
                         i, in_ready, out_valid, out_data, first);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(32'hA0 + 32'(i), 8, 1'b0);
        send_beat(32'h3, 2, 1'b1);
        drain("hold");
    endtask

    task automatic test_reset_mid_stream();
        send_beat(32'hABCDE, 20, 1'b0);
        repeat (2) @(posedge core_clock);
        #1;
        apply_reset();
        repeat (3) @(posedge core_clock);
        #1;
        n_checks++;
        if (obs_q.size() !== 0 || out_valid !== 1'b0 || byte_count !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got beats=%0d vld=%0b bc=%0d, required 0 0 0",
                     obs_q.size(), out_valid, byte_count);
        end
        send_beat(32'h11, 8, 1'b0);
        send_beat(32'h22, 8, 1'b0);
        send_beat(32'h33, 8, 1'b0);
        send_beat(32'h44, 8, 1'b0);
        drain("midreset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            send_beat($urandom, int'($urandom_range(0, 32)), 1'b0);
        end
        send_beat($urandom, 13, 1'b1);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_bytes();
        test_straddle_flush();
        test_mask_pad();
        test_flush_only();
        test_clamp_and_long_flush();
        test_hold();
        test_reset_mid_stream();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
